// File: rtl/opl3_wr_sched_if.sv
// Requester handshakes and OPL3 host-bus signals of the register-write scheduler.
// master = requester/host side, slave = opl3_wr_sched.
interface opl3_wr_sched_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               req0_valid;
    logic               req0_ready;
    logic               req0_bank;
    logic [7:0]         req0_reg;
    logic [7:0]         req0_data;

    logic               req1_valid;
    logic               req1_ready;
    logic               req1_bank;
    logic [7:0]         req1_reg;
    logic [7:0]         req1_data;

    logic [1:0]         opl_addr;
    logic [7:0]         opl_din;
    logic               opl_we;

    logic               busy;
    logic [LEVEL_W-1:0] level;

    modport master (
        output req0_valid, req0_bank, req0_reg, req0_data,
        output req1_valid, req1_bank, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  opl_addr, opl_din, opl_we,
        input  busy, level
    );

    modport slave (
        input  req0_valid, req0_bank, req0_reg, req0_data,
        input  req1_valid, req1_bank, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output opl_addr, opl_din, opl_we,
        output busy, level
    );
endinterface

// File: rtl/opl3_wr_sched.sv
// OPL3 register-write scheduler: round-robin arbiter -> FIFO -> two-port (address/data) replay FSM.
// Optional macro OPL3_WR_SKIP_ADDR_EN: skip the address phase when {bank, reg} repeats.
module opl3_wr_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int WE_WIDTH   = 2,
    parameter int ADDR_WAIT  = 32,
    parameter int DATA_WAIT  = 128
) (
    input logic           clk,
    input logic           rst_n,
    opl3_wr_sched_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Counter reload values: a state lasting N cycles is entered with N-1.
    localparam logic [15:0] WE_CNT   = 16'(WE_WIDTH - 1);
    localparam logic [15:0] AGAP_CNT = 16'(ADDR_WAIT - 1);
    localparam logic [15:0] DGAP_CNT = 16'(DATA_WAIT - 1);
    localparam bit          HAS_AGAP = (ADDR_WAIT > 0);
    localparam bit          HAS_DGAP = (DATA_WAIT > 0);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ADDR_SETUP = 3'd1,
        S_ADDR_PULSE = 3'd2,
        S_ADDR_GAP   = 3'd3,
        S_DATA_SETUP = 3'd4,
        S_DATA_PULSE = 3'd5,
        S_DATA_GAP   = 3'd6
    } state_t;

    // FIFO entry layout: {bank, reg, data}
    function automatic logic [16:0] pack_entry(input logic bank, input logic [7:0] rg,
                                               input logic [7:0] data);
        return {bank, rg, data};
    endfunction

    logic [16:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic [16:0]      entry_r;
    logic [16:0]      head_s;
    logic [16:0]      push_entry_s;
    logic             last_grant_r;
    logic             full_s;
    logic             empty_s;
    logic             ready0_s;
    logic             ready1_s;
    logic             push_s;
    logic             pop_s;
    logic             fetch_s;
    logic             skip_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      cnt_r;
    logic [15:0]      cnt_nxt_s;

    logic [1:0]       opl_addr_r;
    logic [1:0]       opl_addr_nxt_s;
    logic [7:0]       opl_din_r;
    logic [7:0]       opl_din_nxt_s;
    logic             opl_we_r;
    logic             opl_we_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;

    assign full_s  = (level_r == LVL_FULL);
    assign empty_s = (level_r == LVL_ZERO);
    assign head_s  = mem_r[rd_ptr_r];

    // Round-robin arbiter; a tie goes to the port not granted last, nothing is accepted while full.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (!full_s) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_r) begin
                    ready0_s = 1'b1;
                end else begin
                    ready1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                ready0_s = 1'b1;
            end else if (bus.req1_valid) begin
                ready1_s = 1'b1;
            end else begin
                ready0_s = 1'b0;
                ready1_s = 1'b0;
            end
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    assign push_s       = ready0_s | ready1_s;
    assign push_entry_s = ready1_s ? pack_entry(bus.req1_bank, bus.req1_reg, bus.req1_data)
                                   : pack_entry(bus.req0_bank, bus.req0_reg, bus.req0_data);

    // Round-robin pointer: remembers which port won the last accept (reset favours req0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (push_s) begin
            last_grant_r <= ready1_s;
        end
    end

    // FIFO storage array, write port only.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO pointers, occupancy and the registered read of the popped entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
            entry_r  <= 17'd0;
        end else begin
            level_r <= level_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                entry_r  <= head_s;
            end
        end
    end

`ifdef OPL3_WR_SKIP_ADDR_EN
    logic [8:0] last_addr_r;
    logic       last_vld_r;

    assign skip_s = last_vld_r && (head_s[16:8] == last_addr_r);

    // Remembers the {bank, reg} most recently latched into the chip by an address pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld_r  <= 1'b0;
            last_addr_r <= 9'd0;
        end else if (state_r == S_ADDR_PULSE) begin
            last_vld_r  <= 1'b1;
            last_addr_r <= entry_r[16:8];
        end
    end
`else
    assign skip_s = 1'b0;
`endif

    // FSM state and wait-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; fetch_s marks the points where the next FIFO entry may be started.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        fetch_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                fetch_s = 1'b1;
            end
            S_ADDR_SETUP: begin
                state_nxt_s = S_ADDR_PULSE;
                cnt_nxt_s   = WE_CNT;
            end
            S_ADDR_PULSE: begin
                if (cnt_r != 16'd0) begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end else if (HAS_AGAP) begin
                    state_nxt_s = S_ADDR_GAP;
                    cnt_nxt_s   = AGAP_CNT;
                end else begin
                    state_nxt_s = S_DATA_SETUP;
                end
            end
            S_ADDR_GAP: begin
                if (cnt_r != 16'd0) begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end else begin
                    state_nxt_s = S_DATA_SETUP;
                end
            end
            S_DATA_SETUP: begin
                state_nxt_s = S_DATA_PULSE;
                cnt_nxt_s   = WE_CNT;
            end
            S_DATA_PULSE: begin
                if (cnt_r != 16'd0) begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end else if (HAS_DGAP) begin
                    state_nxt_s = S_DATA_GAP;
                    cnt_nxt_s   = DGAP_CNT;
                end else begin
                    fetch_s = 1'b1;
                end
            end
            S_DATA_GAP: begin
                if (cnt_r != 16'd0) begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end else begin
                    fetch_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase

        if (fetch_s) begin
            cnt_nxt_s = 16'd0;
            if (!empty_s) begin
                pop_s       = 1'b1;
                state_nxt_s = skip_s ? S_DATA_SETUP : S_ADDR_SETUP;
            end else begin
                state_nxt_s = S_IDLE;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Bus values for the current state; addr/din hold unless a setup state reloads them.
    always_comb begin
        opl_addr_nxt_s = opl_addr_r;
        opl_din_nxt_s  = opl_din_r;
        opl_we_nxt_s   = 1'b0;
        case (state_r)
            S_IDLE:       opl_we_nxt_s = 1'b0;
            S_ADDR_SETUP: begin
                opl_addr_nxt_s = {entry_r[16], 1'b0};
                opl_din_nxt_s  = entry_r[15:8];
                opl_we_nxt_s   = 1'b0;
            end
            S_ADDR_PULSE: opl_we_nxt_s = 1'b1;
            S_ADDR_GAP:   opl_we_nxt_s = 1'b0;
            S_DATA_SETUP: begin
                opl_addr_nxt_s = {entry_r[16], 1'b1};
                opl_din_nxt_s  = entry_r[7:0];
                opl_we_nxt_s   = 1'b0;
            end
            S_DATA_PULSE: opl_we_nxt_s = 1'b1;
            S_DATA_GAP:   opl_we_nxt_s = 1'b0;
            default:      opl_we_nxt_s = 1'b0;
        endcase
    end

    assign busy_nxt_s = (state_nxt_s != S_IDLE) || (level_nxt_s != LVL_ZERO);

    // Registered OPL3 host-bus outputs and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opl_addr_r <= 2'd0;
            opl_din_r  <= 8'd0;
            opl_we_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            opl_addr_r <= opl_addr_nxt_s;
            opl_din_r  <= opl_din_nxt_s;
            opl_we_r   <= opl_we_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.opl_addr   = opl_addr_r;
    assign bus.opl_din    = opl_din_r;
    assign bus.opl_we     = opl_we_r;
    assign bus.busy       = busy_r;
    assign bus.level      = level_r;
endmodule

// File: tb/tb_opl3_wr_sched.sv
// Directed, scoreboard-based bench for opl3_wr_sched: expected bus pulses are queued on accept
// and compared as each opl_we rising edge appears.
module tb_opl3_wr_sched;
    timeunit 1ns;
    timeprecision 1ns;

    localparam int FIFO_DEPTH = 16;
    localparam int WE_WIDTH   = 2;
    localparam int ADDR_WAIT  = 32;
    localparam int DATA_WAIT  = 128;
    localparam int PERIOD     = 2 + 2 * WE_WIDTH + ADDR_WAIT + DATA_WAIT;
    localparam int CLK_NS     = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    opl3_wr_sched_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    opl3_wr_sched #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .WE_WIDTH  (WE_WIDTH),
        .ADDR_WAIT (ADDR_WAIT),
        .DATA_WAIT (DATA_WAIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          pulse_cnt = 0;
    int          full_seen = 0;
    logic [9:0]  exp_q[$];
    longint      rise_q[$];
    logic [16:0] pay0[$];
    logic [16:0] pay1[$];
    bit          rr_last = 1'b1;
    bit          tb_last_vld = 1'b0;
    logic [8:0]  tb_last = 9'd0;
    longint      first_accept_t = 0;
    longint      t_idle = 0;

    // monitor state
    logic        mon_prev_we = 1'b0;
    int          mon_hi = 0;
    logic [9:0]  mon_cur = 10'd0;
    logic [9:0]  mon_exp = 10'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor: every opl_we rise must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_we = 1'b0;
                mon_hi      = 0;
            end else begin
                if (bus.opl_we === 1'b1 && mon_prev_we === 1'b0) begin
                    pulse_cnt++;
                    rise_q.push_back($time);
                    mon_hi  = 1;
                    mon_cur = {bus.opl_addr, bus.opl_din};
                    check("sb_has_entry", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_exp = exp_q.pop_front();
                        check("pulse_addr_din", mon_cur, mon_exp);
                    end
                end else if (bus.opl_we === 1'b1) begin
                    mon_hi++;
                    check("pulse_hold", {bus.opl_addr, bus.opl_din}, mon_cur);
                end else if (mon_prev_we === 1'b1) begin
                    check("pulse_width", mon_hi, WE_WIDTH);
                end
                mon_prev_we = bus.opl_we;
            end
        end
    end

    task automatic push_expected(input logic [16:0] e);
`ifdef OPL3_WR_SKIP_ADDR_EN
        if (!(tb_last_vld && tb_last == e[16:8])) begin
            exp_q.push_back({e[16], 1'b0, e[15:8]});
        end
        tb_last_vld = 1'b1;
        tb_last     = e[16:8];
`else
        exp_q.push_back({e[16], 1'b0, e[15:8]});
`endif
        exp_q.push_back({e[16], 1'b1, e[7:0]});
    endtask

    // Offer pay0/pay1 to the DUT; grant choice is checked against a round-robin model.
    task automatic drive();
        int          i0 = 0;
        int          i1 = 0;
        int          guard = 0;
        bit          v0;
        bit          v1;
        bit          pg;
        logic [16:0] e;
        while ((i0 < pay0.size() || i1 < pay1.size()) && guard < 20000) begin
            @(negedge clk);
            v0 = (i0 < pay0.size());
            v1 = (i1 < pay1.size());
            bus.req0_valid = v0;
            bus.req1_valid = v1;
            if (v0) {bus.req0_bank, bus.req0_reg, bus.req0_data} = pay0[i0];
            if (v1) {bus.req1_bank, bus.req1_reg, bus.req1_data} = pay1[i1];
            #1;
            pg = (v0 && v1) ? ~rr_last : v1;
            if (bus.req0_ready || bus.req1_ready) begin
                check("grant", {bus.req1_ready, bus.req0_ready}, pg ? 2'b10 : 2'b01);
                e = pg ? pay1[i1] : pay0[i0];
                push_expected(e);
                if (pg) i1++; else i0++;
                rr_last = pg;
                if (first_accept_t == 0) first_accept_t = $time + 4;
            end else begin
                full_seen++;
                check("full_level", bus.level, FIFO_DEPTH);
            end
            guard++;
        end
        check("drive_done", (i0 == pay0.size() && i1 == pay1.size()), 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", bus.busy, 0);
        t_idle = $time;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        rise_q.delete();
        pay0.delete();
        pay1.delete();
        rr_last        = 1'b1;
        tb_last_vld    = 1'b0;
        pulse_cnt      = 0;
        full_seen      = 0;
        first_accept_t = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Watchdog so a stuck design still reports and ends.
    initial begin
        #(80000 * CLK_NS);
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_bank = 1'b0; bus.req0_reg = 8'd0; bus.req0_data = 8'd0;
        bus.req1_valid = 1'b0; bus.req1_bank = 1'b0; bus.req1_reg = 8'd0; bus.req1_data = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", bus.opl_we, 0);
        check("rst_addr", bus.opl_addr, 0);
        check("rst_din", bus.opl_din, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.level, 0);
        rst_n = 1'b1;

        // Single write: latency, phase spacing, busy fall
        pay0.push_back({1'b0, 8'h20, 8'h01});
        drive();
        wait_idle(2000);
        check("t1_pulses", pulse_cnt, 2);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_rises", rise_q.size(), 2);
        if (rise_q.size() == 2) begin
            check("t1_latency", rise_q[0] - first_accept_t, 3 * CLK_NS + 5);
            check("t1_addr_to_data", rise_q[1] - rise_q[0], (1 + WE_WIDTH + ADDR_WAIT) * CLK_NS);
            check("t1_busy_fall", t_idle - rise_q[1], (WE_WIDTH - 1 + DATA_WAIT) * CLK_NS);
        end

        // Both requesters continuously valid: alternating order and back-to-back period
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pay0.push_back({1'b0, 8'h40 + 8'(k), 8'h10 + 8'(k)});
            pay1.push_back({1'b0, 8'h60 + 8'(k), 8'h90 + 8'(k)});
        end
        drive();
        wait_idle(10 * PERIOD);
        check("t2_pulses", pulse_cnt, 16);
        check("t2_sb_empty", exp_q.size(), 0);
        if (rise_q.size() == 16) begin
            for (int k = 0; k < 7; k++) begin
                check("t2_period", rise_q[2 * k + 2] - rise_q[2 * k], PERIOD * CLK_NS);
            end
        end else begin
            check("t2_rises", rise_q.size(), 16);
        end

        // 20 writes from req0: FIFO fills, nothing lost or duplicated
        do_reset();
        for (int k = 0; k < 20; k++) begin
            pay0.push_back({k[0], 8'(k * 7), 8'(8'hC0 ^ 8'(k))});
        end
        drive();
        wait_idle(22 * PERIOD);
        check("t3_pulses", pulse_cnt, 40);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_full_seen", (full_seen > 0), 1);

        // Bank 1 write from req1
        do_reset();
        pay1.push_back({1'b1, 8'h05, 8'h01});
        drive();
        wait_idle(2000);
        check("t4_pulses", pulse_cnt, 2);
        check("t4_sb_empty", exp_q.size(), 0);

        // Reset during the address gap abandons the write
        do_reset();
        pay0.push_back({1'b0, 8'h30, 8'h11});
        pay0.push_back({1'b0, 8'h31, 8'h22});
        drive();
        for (int n = 0; n < 100 && rise_q.size() == 0; n++) @(negedge clk);
        check("t5_addr_pulse_seen", rise_q.size(), 1);
        repeat (10) @(negedge clk);
        check("t5_level_before", bus.level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_we_in_reset", bus.opl_we, 0);
        check("t5_level_in_reset", bus.level, 0);
        check("t5_busy_in_reset", bus.busy, 0);
        exp_q.delete();
        tb_last_vld = 1'b0;
        rr_last     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("t5_no_more_pulses", pulse_cnt, 1);
        check("t5_busy_after", bus.busy, 0);

`ifdef OPL3_WR_SKIP_ADDR_EN
        // Repeated {bank, reg} skips the address phase
        do_reset();
        pay0.push_back({1'b0, 8'hA0, 8'h11});
        pay0.push_back({1'b0, 8'hA0, 8'h22});
        pay0.push_back({1'b0, 8'hA1, 8'h33});
        drive();
        wait_idle(5 * PERIOD);
        check("t6_pulses", pulse_cnt, 5);
        check("t6_sb_empty", exp_q.size(), 0);
        if (rise_q.size() == 5) begin
            check("t6_skip_gap", rise_q[2] - rise_q[1],
                  (PERIOD - (1 + WE_WIDTH + ADDR_WAIT)) * CLK_NS);
            check("t6_full_gap", rise_q[4] - rise_q[2], PERIOD * CLK_NS);
        end else begin
            check("t6_rises", rise_q.size(), 5);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
